iob_fifo_burst_ctrl: RTL and testbench

Read-side scheduler for a synchronous FIFO (iob_fifo_sync flavour, 1-cycle registered read latency). Monitors FIFO level and drains it in fixed-length bursts onto a valid/ready stream with first/last framing. Issues FIFO reads only when downstream space is guaranteed. Sits between a DMA/stream FIFO and a burst-oriented consumer (memory write master, packetiser).

---
 rtl/iob_fifo_burst_ctrl_pkg.sv | 15 +
 rtl/iob_fifo_burst_ctrl_skid_buf2.sv | 56 +++++
 rtl/iob_fifo_burst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_iob_fifo_burst_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_burst_ctrl_pkg.sv
// Shared definitions for the FIFO burst read scheduler.
package iob_fifo_burst_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Skid buffer occupancy ceiling; also the read-outstanding limit.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/iob_fifo_burst_ctrl_skid_buf2.sv
// Two-entry valid/ready output buffer. Entry 0 is always the head and drives
// the outputs, so a stalled beat stays stable until it is popped.
module iob_fifo_burst_ctrl_skid_buf2 #(
    parameter int W = 34
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] ent0_q;
    logic [W-1:0] ent1_q;
    logic [1:0]   occ_q;
    logic         pop;

    assign pop     = pop_i & (occ_q != 2'd0);
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = ent0_q;
    assign occ_o   = occ_q;

    // Entry storage and occupancy; the issue gate upstream prevents overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_q <= push_data_i;
                    else               ent1_q <= push_data_i;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= push_data_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/iob_fifo_burst_ctrl.sv
// Read-side burst scheduler for a synchronous FIFO with 1-cycle read latency.
// Optional partial-burst flush on idle timeout: define IOB_FIFO_BURST_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a full burst (or a timeout flush) with en_i high
// ST_ISSUE | issuing FIFO reads, at most two words outstanding
// ST_DRAIN | all reads issued, waiting for the last beat to be accepted
module iob_fifo_burst_ctrl
    import iob_fifo_burst_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
    input  logic [ADDR_W:0]      fifo_level_i,
    input  logic                 fifo_r_empty_i,
    output logic                 fifo_r_en_o,
    input  logic [DATA_W-1:0]    fifo_r_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_W-1:0]    m_data_o,
    output logic                 m_first_o,
    output logic                 m_last_o,
    output logic [ADDR_W:0]      m_len_o,
    output logic                 busy_o
);

    localparam int LVL_W = ADDR_W + 1;
    localparam logic [LVL_W-1:0] BURST_LEN_L = LVL_W'(BURST_LEN);

    state_t             state_q;
    logic [LVL_W-1:0]   issue_cnt_q;
    logic [LVL_W-1:0]   push_cnt_q;
    logic [LVL_W-1:0]   m_len_q;
    logic               busy_q;
    logic               rd_pend_q;

    logic               rd_en;
    logic               buf_pop;
    logic [1:0]         buf_occ;
    logic [2:0]         room_use;
    logic               push_first;
    logic               push_last;
    logic [DATA_W+1:0]  buf_dout;
    logic               buf_valid;
    logic               start_go;
    logic [LVL_W-1:0]   start_len;

    assign buf_pop = buf_valid & m_ready_i;

    // Words that will sit in the buffer after this cycle's pop, plus the read
    // whose data lands next edge; counting the pop keeps 1 beat/cycle.
    assign room_use = {1'b0, buf_occ} + {2'b00, rd_pend_q} - {2'b00, buf_pop};
    assign rd_en    = (state_q == ST_ISSUE) & (issue_cnt_q != '0) & ~fifo_r_empty_i
                    & (room_use < 3'(SKID_DEPTH));

    assign push_first = (push_cnt_q == '0);
    assign push_last  = (push_cnt_q == m_len_q - LVL_W'(1));

`ifdef IOB_FIFO_BURST_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;
    logic                 partial_wait;

    assign partial_wait = en_i & (fifo_level_i != '0) & (fifo_level_i < BURST_LEN_L);

    // Idle timer for partial flush; full bursts win over a flush in the same cycle.
    always_comb begin
        start_go  = 1'b0;
        start_len = BURST_LEN_L;
        if (state_q == ST_IDLE) begin
            if (en_i && fifo_level_i >= BURST_LEN_L) begin
                start_go = 1'b1;
            end else if (partial_wait && timeout_cfg_i != '0 && to_cnt_q == timeout_cfg_i) begin
                start_go  = 1'b1;
                start_len = fifo_level_i;
            end
        end
    end

    // Counts idle cycles spent holding a sub-burst amount of data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_IDLE && partial_wait && !start_go) begin
            to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^timeout_cfg_i;

    // Only full bursts start; partial data waits in the FIFO.
    always_comb begin
        start_go  = 1'b0;
        start_len = BURST_LEN_L;
        if (state_q == ST_IDLE && en_i && fifo_level_i >= BURST_LEN_L) begin
            start_go = 1'b1;
        end
    end
`endif

    // Burst sequencing FSM with registered length/busy and read tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            push_cnt_q  <= '0;
            m_len_q     <= '0;
            busy_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            rd_pend_q <= rd_en;
            if (rd_pend_q) push_cnt_q <= push_cnt_q + LVL_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        m_len_q     <= start_len;
                        issue_cnt_q <= start_len;
                        push_cnt_q  <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rd_en) begin
                        issue_cnt_q <= issue_cnt_q - LVL_W'(1);
                        if (issue_cnt_q == LVL_W'(1)) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (buf_pop && m_last_o) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    iob_fifo_burst_ctrl_skid_buf2 #(
        .W (DATA_W + 2)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rd_pend_q),
        .push_data_i ({push_first, push_last, fifo_r_data_i}),
        .pop_i       (buf_pop),
        .valid_o     (buf_valid),
        .data_o      (buf_dout),
        .occ_o       (buf_occ)
    );

    assign fifo_r_en_o = rd_en;
    assign m_valid_o   = buf_valid;
    assign m_data_o    = buf_dout[DATA_W-1:0];
    assign m_first_o   = buf_valid & buf_dout[DATA_W+1];
    assign m_last_o    = buf_valid & buf_dout[DATA_W];
    assign m_len_o     = m_len_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_iob_fifo_burst_ctrl.sv
// Scoreboard bench for iob_fifo_burst_ctrl with a behavioural sync FIFO.
`timescale 1ns/1ps
module tb_iob_fifo_burst_ctrl;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT_W = 8;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
        logic [4:0]  len;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        m_ready = 1'b1;
    logic [7:0]  timeout_cfg = 8'd0;
    logic [4:0]  fifo_level;
    logic        fifo_r_empty;
    logic        fifo_r_en;
    logic [31:0] fifo_r_data;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_first;
    logic        m_last;
    logic [4:0]  m_len;
    logic        busy;

    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] mem [0:15];
    logic [3:0]  wptr;
    logic [3:0]  rptr;
    logic [4:0]  cnt;

    int          ready_mode = 0;
    beat_t       exp_q[$];
    beat_t       e;
    int          checks = 0;
    int          failures = 0;
    int          rd_total = 0;
    int          acc_total = 0;
    int          beats_seen = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_data;
    logic        hold_first;
    logic        hold_last;
    logic        busy_chk = 1'b0;

    always #5 clk = ~clk;

    iob_fifo_burst_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .timeout_cfg_i(timeout_cfg),
        .fifo_level_i(fifo_level), .fifo_r_empty_i(fifo_r_empty),
        .fifo_r_en_o(fifo_r_en), .fifo_r_data_i(fifo_r_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_first_o(m_first), .m_last_o(m_last), .m_len_o(m_len), .busy_o(busy)
    );

    // Behavioural synchronous FIFO, registered read data.
    always @(posedge clk) begin
        if (rst) begin
            wptr <= '0; rptr <= '0; cnt <= '0; fifo_r_data <= '0;
        end else begin
            if (wr_en) begin mem[wptr] <= wr_data; wptr <= wptr + 4'd1; end
            if (fifo_r_en) begin fifo_r_data <= mem[rptr]; rptr <= rptr + 4'd1; end
            cnt <= cnt + {4'd0, wr_en} - {4'd0, fifo_r_en};
        end
    end
    assign fifo_level   = cnt;
    assign fifo_r_empty = (cnt == 5'd0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (rst) begin
            rd_total = 0; acc_total = 0; hold = 1'b0; busy_chk = 1'b0;
        end else begin
            if (busy_chk) begin
                chk("busy_after_last", 64'(busy), 64'd0);
                busy_chk = 1'b0;
            end
            if (hold) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(hold_data));
                chk("stall_first", 64'(m_first), 64'(hold_first));
                chk("stall_last", 64'(m_last), 64'(hold_last));
            end
            if (fifo_r_en) rd_total++;
            if (m_valid && m_ready) begin
                acc_total++;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e.data));
                    chk("beat_first", 64'(m_first), 64'(e.first));
                    chk("beat_last", 64'(m_last), 64'(e.last));
                    chk("beat_len", 64'(m_len), 64'(e.len));
                    if (e.last) busy_chk = 1'b1;
                end
            end
            if (fifo_r_en) chk("outstanding_le_2", 64'((rd_total - acc_total) <= 2), 64'd1);
            hold       = m_valid && !m_ready;
            hold_data  = m_data;
            hold_first = m_first;
            hold_last  = m_last;
        end
    end

    // Downstream ready pattern.
    initial forever begin
        @(posedge clk); #1;
        if (ready_mode == 1) m_ready = ~m_ready;
        else                 m_ready = 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_data = 32'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic expect_burst(input int base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = 32'(base + i); b.first = (i == 0); b.last = (i == n - 1); b.len = 5'(n);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drained(input string nm, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin tick(); c++; end
        if (c >= budget) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got %0d beats pending expected 0", nm, exp_q.size());
        end
    endtask

    task automatic wait_busy(input string nm, input logic lvl, input int budget);
        int c = 0;
        while (busy !== lvl && c < budget) begin tick(); c++; end
        if (c >= budget) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got busy %0b expected %0b", nm, busy, lvl);
        end
    endtask

    initial begin
        int rd0;
        int b0;
        int c;
        rst = 1'b1;
        tick(3);
        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_fifo_r_en", 64'(fifo_r_en), 64'd0);
        chk("reset_m_len", 64'(m_len), 64'd0);
        chk("reset_m_data", 64'(m_data), 64'd0);
        chk("reset_m_first", 64'(m_first), 64'd0);
        chk("reset_m_last", 64'(m_last), 64'd0);
        rst = 1'b0;
        tick();

        // Single full burst, ready held high.
        en = 1'b1; ready_mode = 0;
        expect_burst(0, 8);
        write_words(0, 8);
        wait_drained("t1", 200);

        // Full burst with ready toggling.
        ready_mode = 1;
        expect_burst(32'h100, 8);
        write_words(32'h100, 8);
        wait_drained("t2", 300);
        ready_mode = 0;
        tick(2);

        // Two back-to-back bursts, one idle cycle between.
        en = 1'b0;
        write_words(32'h200, 16);
        expect_burst(32'h200, 8);
        expect_burst(32'h208, 8);
        en = 1'b1;
        wait_busy("t3_rise", 1'b1, 20);
        wait_busy("t3_fall", 1'b0, 100);
        c = 0;
        while (!busy && c < 20) begin tick(); c++; end
        chk("idle_gap_cycles", 64'(c), 64'd1);
        wait_drained("t3", 200);

        // en low blocks starts; en dropped mid-burst lets it finish.
        en = 1'b0;
        rd0 = rd_total;
        write_words(32'h300, 8);
        tick(20);
        chk("no_read_en_low", 64'(rd_total - rd0), 64'd0);
        write_words(32'h308, 8);
        expect_burst(32'h300, 8);
        b0 = beats_seen;
        en = 1'b1;
        c = 0;
        while (beats_seen == b0 && c < 50) begin tick(); c++; end
        en = 1'b0;
        wait_drained("t4", 200);
        tick(20);
        chk("no_second_burst_busy", 64'(busy), 64'd0);
        chk("reads_one_burst", 64'(rd_total - rd0), 64'd8);

        // Reset during the fourth beat of a burst.
        expect_burst(32'h308, 8);
        b0 = beats_seen;
        en = 1'b1;
        c = 0;
        while (beats_seen < b0 + 3 && c < 100) begin tick(); c++; end
        chk("t5_three_beats", 64'(beats_seen - b0), 64'd3);
        rst = 1'b1;
        tick();
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_fifo_r_en", 64'(fifo_r_en), 64'd0);
        chk("midrst_m_len", 64'(m_len), 64'd0);
        exp_q.delete();
        en = 1'b0;
        rst = 1'b0;
        tick();

        // Partial data below a full burst.
`ifdef IOB_FIFO_BURST_TIMEOUT_EN
        timeout_cfg = 8'd0;
        en = 1'b1;
        rd0 = rd_total;
        write_words(32'h400, 3);
        tick(30);
        chk("cfg0_no_flush", 64'(rd_total - rd0), 64'd0);
        timeout_cfg = 8'd5;
        expect_burst(32'h400, 3);
        wait_drained("t6_flush", 600);
`else
        timeout_cfg = 8'd5;
        en = 1'b1;
        rd0 = rd_total;
        write_words(32'h400, 3);
        tick(40);
        chk("no_partial_reads", 64'(rd_total - rd0), 64'd0);
        chk("no_partial_busy", 64'(busy), 64'd0);
`endif
        tick(5);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

endmodule
